// File: rtl/dm_access_ctrl.sv
// Sequences MEM-stage loads/stores onto a single-port synchronous data memory,
// splitting word-crossing accesses into two word transactions and extending load data.
module dm_access_ctrl #(
    parameter int ADDR_W           = 10,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD1, RD2, WR2, DONE} state_t;

    state_t            state;
    logic [1:0]        o_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              split_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       whi_q;
    logic [3:0]        mhi_q;
    logic [31:0]       lo_q;

    logic [1:0]        o;
    logic [3:0]        base;
    logic [7:0]        m;
    logic [63:0]       w64;
    logic              split;
    logic              fault;
    logic [ADDR_W-1:0] a;
    logic              accept;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

    // Request decode: lane mask and lane-aligned store data over two words
    always_comb begin
        o = req_addr[1:0];
        case (req_size)
            2'd0:    base = 4'h1;
            2'd1:    base = 4'h3;
            default: base = 4'hF;
        endcase
        m     = {4'b0000, base} << o;
        w64   = {32'h0, req_wdata} << {o, 3'b000};
        split = |m[7:4];
        fault = split && (ALLOW_MISALIGNED == 1'b0);
        a     = req_addr[ADDR_W+1:2];
    end

    assign resp_valid = (state == RD1 && !split_q) || state == RD2 || state == DONE;
    assign req_ready  = !rst && (state == IDLE || resp_valid);
    assign accept     = req_valid && req_ready;
    assign resp_err   = (state == DONE) && err_q;

    function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] sz,
                                        input logic u);
        case (sz)
            2'd0:    ext = {{24{~u & d[7]}}, d[7:0]};
            2'd1:    ext = {{16{~u & d[15]}}, d[15:0]};
            default: ext = d;
        endcase
    endfunction

    logic [63:0] ld_src;
    logic [31:0] ld_aligned;

    always_comb begin
        ld_src     = (state == RD2) ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
        ld_aligned = 32'(ld_src >> {o_q, 3'b000});
        resp_rdata = 32'h0;
        if ((state == RD1 && !split_q) || state == RD2)
            resp_rdata = ext(ld_aligned, size_q, uns_q);
    end

    // Second halves of split accesses own the port; a response cycle may issue a new request
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (state == RD1 && split_q) begin
            mem_en   = 1'b1;
            mem_addr = addr_q + ADDR_W'(1);
        end else if (state == WR2) begin
            mem_en    = 1'b1;
            mem_we    = mhi_q;
            mem_addr  = addr_q + ADDR_W'(1);
            mem_wdata = whi_q;
        end else if (accept && !fault) begin
            mem_en    = 1'b1;
            mem_we    = req_we ? m[3:0] : 4'h0;
            mem_addr  = a;
            mem_wdata = w64[31:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            o_q     <= 2'd0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            whi_q   <= 32'h0;
            mhi_q   <= 4'h0;
            lo_q    <= 32'h0;
        end else if (state == RD1 && split_q) begin
            lo_q  <= mem_rdata;
            state <= RD2;
        end else if (state == WR2) begin
            state <= DONE;
        end else if (accept) begin
            o_q     <= o;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            split_q <= split;
            err_q   <= fault;
            addr_q  <= a;
            whi_q   <= w64[63:32];
            mhi_q   <= m[7:4];
            if (fault)
                state <= DONE;
            else if (!req_we)
                state <= RD1;
            else
                state <= split ? WR2 : DONE;
        end else begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Randomised and directed bench for dm_access_ctrl against a byte-addressed memory model.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, f_valid = 1'b0;
    logic        req_we = 1'b0, req_unsigned = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;

    logic        req_ready, resp_valid, resp_err, mem_en;
    logic [31:0] resp_rdata, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [3:0]  mem_we;
    logic [9:0]  mem_addr;

    logic        f_ready, f_resp_valid, f_err, f_mem_en;
    logic [31:0] f_rdata, f_mem_wdata;
    logic [31:0] f_mem_rdata = 32'h0;
    logic [3:0]  f_mem_we;
    logic [9:0]  f_mem_addr;

    always #5 clk = ~clk;

    dm_access_ctrl #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata));

    dm_access_ctrl #(.ADDR_W(10), .ALLOW_MISALIGNED(1'b0)) dut_f (
        .clk(clk), .rst(rst), .req_valid(f_valid), .req_ready(f_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(f_resp_valid),
        .resp_rdata(f_rdata), .resp_err(f_err), .mem_en(f_mem_en),
        .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .mem_rdata(f_mem_rdata));

    // Synchronous single-port memory behind the main instance, with a bench preload port
    logic [31:0] mem [0:1023];
    logic        poke_en = 1'b0;
    logic [9:0]  poke_addr = 10'd0;
    logic [31:0] poke_dat = 32'h0;

    always @(posedge clk) begin
        if (poke_en)
            mem[poke_addr] <= poke_dat;
        else if (mem_en) begin
            if (mem_we == 4'h0)
                mem_rdata <= mem[mem_addr];
            else
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    // Reference: flat byte array, 4096 bytes, addresses taken modulo its size
    logic [7:0] rb [0:4095];
    int n_cmp = 0, n_bad = 0;

    logic        cap_en [0:1];
    logic [3:0]  cap_we [0:1];
    logic [9:0]  cap_a  [0:1];
    logic [31:0] cap_wd [0:1];
    int          lat;
    logic [31:0] got_rd;
    logic        got_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic int bidx(input logic [31:0] a, input int i);
        return (int'(a[11:0]) + i) % 4096;
    endfunction

    function automatic logic crosses(input logic [31:0] a, input logic [1:0] s);
        return (int'(a[1:0]) + nbytes(s)) > 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s,
                                             input logic u);
        logic [31:0] v;
        int n;
        v = 32'h0;
        n = nbytes(s);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rb[bidx(a, i)];
        for (int i = n; i < 4; i++) v[8*i +: 8] = (!u && v[8*n-1]) ? 8'hFF : 8'h00;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] wd);
        for (int i = 0; i < nbytes(s); i++) rb[bidx(a, i)] = wd[8*i +: 8];
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = w[9:0]; poke_dat = v;
        @(posedge clk); #1;
        poke_en = 1'b0;
        for (int b = 0; b < 4; b++) rb[w*4 + b] = v[8*b +: 8];
    endtask

    task automatic txn(input logic we, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = u;
        req_addr = a; req_wdata = wd;
        #1;
        check("req_ready", 32'(req_ready), 1);
        cap_en[0] = mem_en; cap_we[0] = mem_we; cap_a[0] = mem_addr; cap_wd[0] = mem_wdata;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        cap_en[1] = mem_en; cap_we[1] = mem_we; cap_a[1] = mem_addr; cap_wd[1] = mem_wdata;
        lat = 1;
        while (!resp_valid && lat < 4) begin
            @(negedge clk); #1;
            lat++;
        end
        got_rd = resp_rdata; got_err = resp_err;
    endtask

    task automatic chk_txn(input logic we, input logic [1:0] sz, input logic u,
                           input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] exp_rd;
        exp_rd = we ? 32'h0 : ref_load(a, sz, u);
        txn(we, sz, u, a, wd);
        check("latency", lat, crosses(a, sz) ? 2 : 1);
        check("rdata", got_rd, exp_rd);
        check("err", 32'(got_err), 0);
        check("issue_addr", 32'(cap_a[0]), 32'(a[11:2]));
        if (we) ref_store(a, sz, wd);
    endtask

    initial begin
        // Outputs held at zero through reset even with a request presented
        req_valid = 1'b1; f_valid = 1'b1; req_we = 1'b1; req_addr = 32'h16;
        req_wdata = 32'hFFFF_FFFF;
        #2;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_rdata", resp_rdata, 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_mem_en", 32'(mem_en), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_f_mem_en", 32'(f_mem_en), 0);
        req_valid = 1'b0; f_valid = 1'b0; req_we = 1'b0;
        for (int w = 0; w < 1024; w++) poke(w, $urandom);
        @(negedge clk); rst = 1'b0;

        // Single-word loads with extension
        poke(5, 32'h80FF7F01);
        txn(1'b0, 2'd0, 1'b0, 32'h15, 32'h0);
        check("lb_15", got_rd, 32'h0000007F);
        check("lb_15_lat", lat, 1);
        txn(1'b0, 2'd0, 1'b1, 32'h17, 32'h0);
        check("lbu_17", got_rd, 32'h00000080);
        txn(1'b0, 2'd1, 1'b0, 32'h16, 32'h0);
        check("lh_16", got_rd, 32'hFFFF80FF);

        // Split loads
        poke(5, 32'h44332211);
        poke(6, 32'h88776655);
        txn(1'b0, 2'd2, 1'b0, 32'h17, 32'h0);
        check("lw_17", got_rd, 32'h77665544);
        check("lw_17_lat", lat, 2);
        check("lw_17_rd0", {cap_en[0], cap_we[0], 22'(cap_a[0])}, {1'b1, 4'h0, 22'd5});
        check("lw_17_rd1", {cap_en[1], cap_we[1], 22'(cap_a[1])}, {1'b1, 4'h0, 22'd6});
        txn(1'b0, 2'd1, 1'b0, 32'h17, 32'h0);
        check("lh_17", got_rd, 32'h00005544);

        // Split store
        txn(1'b1, 2'd2, 1'b0, 32'h16, 32'hAABBCCDD);
        check("sw_c0", {cap_we[0], 28'(cap_a[0])}, {4'b1100, 28'd5});
        check("sw_c0_wd", cap_wd[0], 32'hCCDD0000);
        check("sw_c1", {cap_we[1], 28'(cap_a[1])}, {4'b0011, 28'd6});
        check("sw_c1_wd", cap_wd[1], 32'h0000AABB);
        check("sw_lat", lat, 2);
        check("sw_mem5", mem[5], 32'hCCDD2211);
        check("sw_mem6", mem[6], 32'h8877AABB);
        ref_store(32'h16, 2'd2, 32'hAABBCCDD);

        // Back-to-back aligned loads with req_valid held
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
        #1;
        check("b2b_c0", {mem_en, 22'(mem_addr)}, {1'b1, 22'd0});
        @(negedge clk); req_addr = 32'h4; #1;
        check("b2b_r0", {31'(resp_valid), req_ready}, {31'd1, 1'b1});
        check("b2b_d0", resp_rdata, ref_load(32'h0, 2'd2, 1'b0));
        check("b2b_c1", {mem_en, 22'(mem_addr)}, {1'b1, 22'd1});
        @(negedge clk); req_addr = 32'h8; #1;
        check("b2b_d1", {31'(resp_valid), 1'b0} | 32'(resp_rdata == ref_load(32'h4, 2'd2, 1'b0)),
              32'd3);
        check("b2b_c2", {mem_en, 22'(mem_addr)}, {1'b1, 22'd2});
        @(negedge clk); req_valid = 1'b0; #1;
        check("b2b_r2", 32'(resp_valid), 1);
        check("b2b_d2", resp_rdata, ref_load(32'h8, 2'd2, 1'b0));
        check("b2b_idle_en", 32'(mem_en), 0);
        @(negedge clk); #1;
        check("b2b_end", 32'(resp_valid), 0);

        // Fault instance: misaligned word faults, aligned half stores
        @(negedge clk);
        f_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h2;
        #1;
        check("flt_ready", 32'(f_ready), 1);
        check("flt_mem_en", 32'(f_mem_en), 0);
        @(negedge clk); f_valid = 1'b0; #1;
        check("flt_resp", {30'(f_resp_valid), f_err, f_mem_en}, {30'd1, 1'b1, 1'b0});
        check("flt_rdata", f_rdata, 0);
        @(negedge clk);
        f_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_addr = 32'h2;
        req_wdata = 32'h00001234;
        #1;
        check("sh_we", {27'(f_mem_en), f_mem_we}, {27'd1, 4'b1100});
        check("sh_wd", f_mem_wdata, 32'h12340000);
        @(negedge clk); f_valid = 1'b0; #1;
        check("sh_resp", {31'(f_resp_valid), f_err}, {31'd1, 1'b0});

        // Reset during the second half of a split store
        poke(6, 32'h5A5A5A5A);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h16;
        req_wdata = 32'h13572468;
        #1;
        check("rs_c0", 32'(mem_en), 1);
        @(negedge clk); req_valid = 1'b0; rst = 1'b1; #1;
        check("rs_mem_en", {mem_en, mem_we, resp_valid, req_ready}, 7'd0);
        check("rs_mem_addr", 32'(mem_addr), 0);
        @(negedge clk); rst = 1'b0; #1;
        check("rs_no_resp", 32'(resp_valid), 0);
        check("rs_mem6", mem[6], 32'h5A5A5A5A);
        ref_store(32'h16, 2'd1, 32'h00002468);
        chk_txn(1'b0, 2'd2, 1'b0, 32'h14, 32'h0);

        // Wrap from the last word to word 0
        chk_txn(1'b0, 2'd2, 1'b0, 32'h0000_0FFD, 32'h0);
        check("wrap_a1", 32'(cap_a[1]), 0);
        chk_txn(1'b1, 2'd2, 1'b0, 32'hF000_0FFE, 32'hDEADBEEF);
        chk_txn(1'b0, 2'd1, 1'b1, 32'h0000_0FFF, 32'h0);

        for (int i = 0; i < 300; i++)
            chk_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), $urandom, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
